// File: rtl/rf_pkg.sv
// rf_pkg: definitions shared by the register file and the hazard unit.
//   rf_state_t        - sweep sequencer state encoding (ST_CLEAR, ST_READY)
//   RF_DATA_W/DEPTH/ADDR_W - default geometry of the pipeline register file
package rf_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

endpackage : rf_pkg

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: clear-sweep sequencer for the register file.
// Walks a counter over every entry after reset or on request, asking the
// array to write zero at each step, then parks in ST_READY.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   i_clr_req    - one-cycle request to re-run the sweep (honoured in READY only)
//   o_busy       - high for every cycle spent in ST_CLEAR
//   o_clr_we     - write-zero strobe for the array
//   o_clr_addr   - entry being cleared this cycle
//   o_state      - current FSM state, exported for observation
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output rf_state_t         o_state
);

  // Exit compare sits on the last entry so the counter never wraps and a
  // non-power-of-two DEPTH is covered exactly.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // A clr_req arriving mid-sweep is ignored; the sweep just continues.
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (i_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clr_addr = r_cnt;
  assign o_state    = r_state;

endmodule : rf_clear_seq

// File: rtl/rf_multiport.sv
// rf_multiport: ID-stage register file, NUM_RD combinational read ports,
// one write port with same-cycle write-to-read bypass, sweep-based clear and
// a registered debug tap.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   i_clr_req    - pulse to re-clear every entry
//   o_busy       - sweep running; front end must stall
//   i_we/i_waddr/i_wdata - write port (dropped while busy)
//   i_raddr      - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   o_rdata      - packed read data, port i at [i*DATA_W +: DATA_W]
//   i_dbg_addr   - debug tap select
//   o_dbg_data   - registered array contents at i_dbg_addr (no bypass)
//   o_state      - sequencer state, exported for observation
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr_req,
  output logic                     o_busy,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  input  logic [ADDR_W-1:0]        i_dbg_addr,
  output logic [DATA_W-1:0]        o_dbg_data,
  output rf_state_t                o_state
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dbg;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;
  logic              w_dbg_ok;

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (i_clr_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_state    (o_state)
  );

  // A port write is accepted only in READY, in range, and not to the
  // hardwired zero entry. The same qualifier gates the read bypass so a
  // bypassed value is always one the array will actually hold.
  assign w_wr_ok = !w_busy && i_we && ({1'b0, i_waddr} < DEPTH_W) &&
                   !((ZERO_REG != 0) && (i_waddr == '0));

  // The sweep owns the write path while busy; a port write then is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end else if (w_wr_ok) begin
        r_mem[i_waddr] <= i_wdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = i_raddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        w_rd = '0;
        if (!w_busy && ({1'b0, w_ra} < DEPTH_W) &&
            !((ZERO_REG != 0) && (w_ra == '0))) begin
          if (w_wr_ok && (i_waddr == w_ra)) begin
            w_rd = i_wdata;
          end else begin
            w_rd = r_mem[w_ra];
          end
        end
      end

      assign o_rdata[gi*DATA_W +: DATA_W] = w_rd;
    end
  endgenerate

  assign w_dbg_ok = ({1'b0, i_dbg_addr} < DEPTH_W);

  // Samples the array before any same-edge write lands, so a write to the
  // tapped entry shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dbg <= '0;
    end else if (w_dbg_ok) begin
      r_dbg <= r_mem[i_dbg_addr];
    end else begin
      r_dbg <= '0;
    end
  end

  assign o_busy     = w_busy;
  assign o_dbg_data = r_dbg;

endmodule : rf_multiport

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed checks of rf_multiport in the default geometry
// (instance a) and in a 24-entry, 3-port, 64-bit geometry (instance b).
module tb_rf_multiport;
  import rf_pkg::*;

  logic clk;
  logic rst_n;

  // instance a: defaults
  logic        a_clr_req;
  logic        a_busy;
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [4:0]  a_dbg_addr;
  logic [31:0] a_dbg_data;
  rf_state_t   a_state;

  // instance b: DEPTH=24, NUM_RD=3, DATA_W=64
  logic         b_clr_req;
  logic         b_busy;
  logic         b_we;
  logic [4:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic [14:0]  b_raddr;
  logic [191:0] b_rdata;
  logic [4:0]   b_dbg_addr;
  logic [63:0]  b_dbg_data;
  rf_state_t    b_state;

  int n_vec;
  int n_err;
  int cnt_a;
  int cnt_b;

  rf_multiport u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (a_clr_req),
    .o_busy     (a_busy),
    .i_we       (a_we),
    .i_waddr    (a_waddr),
    .i_wdata    (a_wdata),
    .i_raddr    (a_raddr),
    .o_rdata    (a_rdata),
    .i_dbg_addr (a_dbg_addr),
    .o_dbg_data (a_dbg_data),
    .o_state    (a_state)
  );

  rf_multiport #(
    .DATA_W (64),
    .DEPTH  (24),
    .ADDR_W (5),
    .NUM_RD (3)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (b_clr_req),
    .o_busy     (b_busy),
    .i_we       (b_we),
    .i_waddr    (b_waddr),
    .i_wdata    (b_wdata),
    .i_raddr    (b_raddr),
    .o_rdata    (b_rdata),
    .i_dbg_addr (b_dbg_addr),
    .o_dbg_data (b_dbg_data),
    .o_state    (b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_clr_req = 1'b0; a_we = 1'b0; a_waddr = '0; a_wdata = '0;
    a_raddr = '0; a_dbg_addr = '0;
    b_clr_req = 1'b0; b_we = 1'b0; b_waddr = '0; b_wdata = '0;
    b_raddr = '0; b_dbg_addr = '0;

    // reset held for 3 cycles
    repeat (3) tick();
    check("rst_busy_a", 64'(a_busy), 64'd1);
    check("rst_state_a", 64'(a_state), 64'(ST_CLEAR));
    check("rst_dbg_a", 64'(a_dbg_data), 64'd0);
    check("rst_dbg_b", b_dbg_data, 64'd0);
    a_raddr = {5'd9, 5'd3};
    #1;
    check("rst_rdata_a", a_rdata, 64'd0);

    // release: count busy cycles on both geometries
    rst_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      if (k == 10) begin
        a_raddr = {5'd31, 5'd17};
        b_raddr = {5'd23, 5'd12, 5'd1};
        #1;
        check("sweep_rdata_a", a_rdata, 64'd0);
        check("sweep_rdata_b", b_rdata[63:0] | b_rdata[127:64] | b_rdata[191:128], 64'd0);
      end
      tick();
    end
    check("busy_len_a", 64'(cnt_a), 64'd32);
    check("busy_len_b", 64'(cnt_b), 64'd24);
    check("ready_busy_a", 64'(a_busy), 64'd0);
    check("ready_state_a", 64'(a_state), 64'(ST_READY));

    // write r5 with same-cycle bypass on port 0
    a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
    a_raddr = {5'd6, 5'd5};
    #1;
    check("bypass_p0", 64'(a_rdata[31:0]), 64'hDEADBEEF);
    check("bypass_p1_other", 64'(a_rdata[63:32]), 64'd0);
    tick();
    a_we = 1'b0;
    a_raddr = {5'd5, 5'd6};
    #1;
    check("stored_p1", 64'(a_rdata[63:32]), 64'hDEADBEEF);
    check("stored_p0_other", 64'(a_rdata[31:0]), 64'd0);

    // zero register
    a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'h1234;
    a_raddr = {5'd0, 5'd0};
    #1;
    check("zero_bypass", a_rdata, 64'd0);
    tick();
    a_we = 1'b0;
    #1;
    check("zero_later", a_rdata, 64'd0);

    // debug tap: r19 = 0x11, then 0x55 written while tapped
    a_we = 1'b1; a_waddr = 5'd19; a_wdata = 32'h11;
    tick();
    a_dbg_addr = 5'd19;
    a_waddr = 5'd19; a_wdata = 32'h55;
    tick();
    check("dbg_old", 64'(a_dbg_data), 64'h11);
    a_we = 1'b0;
    tick();
    check("dbg_new", 64'(a_dbg_data), 64'h55);

    // fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      a_we = 1'b1; a_waddr = 5'(i); a_wdata = 32'(i);
      tick();
    end
    a_we = 1'b0;
    a_raddr = {5'd31, 5'd17};
    #1;
    check("fill_r17", 64'(a_rdata[31:0]), 64'd17);
    check("fill_r31", 64'(a_rdata[63:32]), 64'd31);

    // re-clear with a simultaneous write to r7
    a_clr_req = 1'b1;
    a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'hAA;
    a_raddr = {5'd9, 5'd7};
    #1;
    check("clr_req_busy", 64'(a_busy), 64'd0);
    check("clr_req_bypass", 64'(a_rdata[31:0]), 64'hAA);
    tick();
    a_clr_req = 1'b0;
    a_we = 1'b0;
    #1;
    check("clr_r7_busy_read", 64'(a_rdata[31:0]), 64'd0);
    check("clr_r9_busy_read", 64'(a_rdata[63:32]), 64'd0);
    cnt_a = 0;
    for (int k = 0; k < 50; k++) begin
      if (a_busy) cnt_a++;
      // a request mid-sweep must not restart it
      a_clr_req = (k == 5);
      a_we = (k == 6);
      a_waddr = 5'd3; a_wdata = 32'h77;
      tick();
    end
    a_clr_req = 1'b0;
    a_we = 1'b0;
    check("reclr_busy_len", 64'(cnt_a), 64'd32);
    for (int i = 0; i < 32; i++) begin
      a_raddr = {5'(i), 5'(i)};
      #1;
      check($sformatf("reclr_r%0d", i), a_rdata, 64'd0);
    end
    a_dbg_addr = 5'd7;
    tick();
    check("reclr_dbg_r7", 64'(a_dbg_data), 64'd0);

    // geometry b: out-of-range write ignored, in-range bypass and store
    b_we = 1'b1; b_waddr = 5'd30; b_wdata = 64'hFFFF_0000_FFFF_0000;
    b_raddr = {5'd24, 5'd23, 5'd30};
    #1;
    check("b_oor_bypass", b_rdata[63:0], 64'd0);
    tick();
    b_waddr = 5'd23; b_wdata = 64'h0123_4567_89AB_CDEF;
    #1;
    check("b_oor_read", b_rdata[63:0], 64'd0);
    check("b_bypass_r23", b_rdata[127:64], 64'h0123_4567_89AB_CDEF);
    check("b_read_r24", b_rdata[191:128], 64'd0);
    tick();
    b_we = 1'b0;
    b_dbg_addr = 5'd30;
    #1;
    check("b_stored_r23", b_rdata[127:64], 64'h0123_4567_89AB_CDEF);
    check("b_oor_after", b_rdata[63:0], 64'd0);
    tick();
    check("b_dbg_oor", b_dbg_data, 64'd0);
    b_dbg_addr = 5'd23;
    tick();
    check("b_dbg_r23", b_dbg_data, 64'h0123_4567_89AB_CDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rf_multiport

// File: doc/rf_multiport.md
# rf_multiport

Parametrised successor to the pipeline register file: `NUM_RD` combinational read ports and one write port, with same-cycle write-to-read bypass. Storage is cleared by a sequential sweep engine rather than a flat reset, and the sweep can be re-run on request. A registered, selectable debug tap replaces the fixed single-register probe. The block sits in the ID stage; `busy` stalls the front end while a sweep is running.

## Interface
- `DATA_W`, default 32: register width.
- `DEPTH`, default 32: number of entries.
- `ADDR_W`, default 5: address width; must satisfy 2^ADDR_W >= DEPTH.
- `NUM_RD`, default 2: number of read ports.
- `ZERO_REG`, default 1: when 1, entry 0 is hardwired to zero.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `clr_req`  in  1  one-cycle pulse; re-clears all entries.
- `busy`  out  1  high while a sweep is running.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `raddr`  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- `rdata`  out  NUM_RD*DATA_W  packed read data, combinational.
- `dbg_addr`  in  ADDR_W  debug tap select.
- `dbg_data`  out  DATA_W  registered debug tap.

## Operation
- **FSM states:** CLEAR and READY. A sweep counter `cnt` has ADDR_W bits.
- **Reset:** while `rst_n`=0, state=CLEAR, `cnt`=0, `dbg_data`=0. No array writes occur during reset.
- **CLEAR:**
  - Each clock writes 0 to entry `cnt`, then `cnt`++.
  - When `cnt`==DEPTH-1, transition to READY.
  - `busy`=1. All `rdata` ports read 0.
  - `we` is dropped, not queued.
  - `clr_req` is ignored; the sweep does not restart.
- **READY:**
  - `busy`=0.
  - `clr_req`=1 moves to CLEAR with `cnt`=0 at the next edge.
  - A `we` in the same cycle as `clr_req` is still performed. The sweep then overwrites it.
- **Write:** takes effect at the edge when state=READY, `we`=1, and `waddr`<DEPTH. It is suppressed when ZERO_REG=1 and `waddr`==0.
- **Read port i:**
  - Returns 0 if busy, or `raddr_i`>=DEPTH, or (ZERO_REG=1 and `raddr_i`==0).
  - Otherwise, if `we` and `waddr`==`raddr_i` (write would be accepted this cycle), returns `wdata` (bypass).
  - Otherwise returns the array entry.
- **Debug tap:** each edge in READY or CLEAR, `dbg_data` <= array[`dbg_addr`]. It has no bypass. It reads 0 for `dbg_addr`>=DEPTH.
- **Reset mid-sweep or mid-operation:** aborts the sweep and restarts it from entry 0 after release.

## Timing
- `rdata`: zero-cycle latency (combinational from `raddr`, `we`, `waddr`, `wdata`, and state).
- A write is visible in the array one edge after acceptance. It is visible in the same cycle via bypass.
- **After reset release:** `busy` is high for exactly DEPTH cycles and falls after the DEPTH-th rising edge with `rst_n`=1.
- **`clr_req` in READY:** `busy` rises the next cycle and stays high DEPTH cycles.
- `dbg_data`: one-cycle latency. It shows pre-write contents on a same-cycle write.
- `cnt` never wraps. The exit compare is at DEPTH-1, so non-power-of-two DEPTH is legal.

## Structure
- **Shared package `rf_pkg`:** FSM state encoding (ST_CLEAR, ST_READY) and default DATA_W/DEPTH/ADDR_W constants, shared with the hazard unit.
- **Sub-module `rf_clear_seq`:** FSM plus sweep counter. Outputs: `busy`, `clr_we`, `clr_addr`.
- The top level holds the array, write arbitration (sweep over port), read/bypass muxing per port via generate loop, and the debug register.

## Test plan
- **Reset sweep:** hold `rst_n`=0 for 3 cycles, release. Expect `busy`=1 for 32 cycles, then 0. Every `raddr` reads 0.
- **Write/read and bypass:** write 0xDEADBEEF to r5. Same cycle, `raddr0`=5 gives 0xDEADBEEF. Next cycle, `raddr1`=5 gives 0xDEADBEEF.
- **Zero register:** write 0x1234 to r0. Expect `rdata`=0 for r0 on both the bypass cycle and later.
- **Re-clear:** fill r1..r31 with index values. Pulse `clr_req` together with a `we` to r7=0xAA. Expect `busy` for 32 cycles, then r7=0 and all entries 0.
- **Debug tap:** `dbg_addr`=19 with r19 written 0x55 at edge k. Expect `dbg_data`=old value at edge k+1 and 0x55 at edge k+2.
- **Parametrisation:** DEPTH=24, NUM_RD=3, DATA_W=64. `busy` lasts 24 cycles. `raddr`=30 reads 0, and a write to 30 is ignored.
